// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// instruction_fetch
// Fetch stage of the RV32I core. It keeps the next-fetch PC, issues word reads
// to instruction memory over a req/ack handshake, and presents each returned
// word together with its PC to the decoder and immediate_generator. A
// one-entry skid buffer absorbs the word that returns while the downstream
// stage is stalled. A redirect (taken branch/jump) flushes the stage, and any
// read already in flight is drained and discarded.
//
// Ports:
//   I_clk          clock, rising edge
//   I_rst          synchronous active-high reset
//   I_stall        downstream cannot accept; output register holds
//   I_redirect     load I_redirect_pc and flush
//   I_redirect_pc  redirect target (bits [1:0] ignored)
//   O_imem_req     instruction memory read request
//   O_imem_addr    word-aligned read address
//   I_imem_ack     memory returns I_imem_data this cycle
//   I_imem_data    read data
//   O_instr        instruction register (NOP_INSTR after reset/flush)
//   O_pc           address O_instr was fetched from
//   O_valid        O_instr/O_pc hold a valid instruction
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_stall,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_imem_req,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_ack,
  input  logic [31:0] I_imem_data,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_valid
);

  typedef enum logic {FETCH, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_full_q, skid_full_d;

  logic        ack_fire;
  logic        consume;
  logic [31:0] redirect_target;

  // A request is driven whenever nothing blocks it: in DROP the old read must
  // be held until its ack, in FETCH a full skid means there is nowhere to put
  // the next word. The request is therefore held stable by construction,
  // because pc only moves on an ack and a redirect of a live request moves
  // the address source over to drop_addr.
  assign O_imem_req      = !I_rst && ((state_q == DROP) || !skid_full_q);
  assign O_imem_addr     = (state_q == DROP) ? drop_addr_q : pc_q;
  assign ack_fire        = O_imem_req && I_imem_ack;
  assign consume         = valid_q && !I_stall;
  assign redirect_target = I_redirect_pc & 32'hFFFF_FFFC;

  assign O_instr = instr_q;
  assign O_pc    = out_pc_q;
  assign O_valid = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    instr_d      = instr_q;
    out_pc_d     = out_pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_full_d  = skid_full_q;

    if (I_redirect) begin
      pc_d        = redirect_target;
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      skid_full_d = 1'b0;
      if (state_q == FETCH) begin
        // A live read without its ack must be drained at its old address.
        if (O_imem_req && !I_imem_ack) begin
          state_d     = DROP;
          drop_addr_d = pc_q;
        end
      end else if (ack_fire) begin
        state_d = FETCH;
      end
    end else if (state_q == DROP) begin
      if (ack_fire) begin
        state_d = FETCH;
      end
    end else begin
      if (ack_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (consume) begin
        if (skid_full_q) begin
          instr_d     = skid_instr_q;
          out_pc_d    = skid_pc_q;
          skid_full_d = 1'b0;
        end else if (ack_fire) begin
          instr_d  = I_imem_data;
          out_pc_d = pc_q;
        end else begin
          valid_d = 1'b0;
        end
      end else if (ack_fire) begin
        if (!valid_q) begin
          instr_d  = I_imem_data;
          out_pc_d = pc_q;
          valid_d  = 1'b1;
        end else begin
          skid_instr_d = I_imem_data;
          skid_pc_d    = pc_q;
          skid_full_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      instr_q      <= NOP_INSTR;
      out_pc_q     <= RESET_PC;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      skid_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      instr_q      <= instr_d;
      out_pc_q     <= out_pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_full_q  <= skid_full_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Bench for instruction_fetch. Instruction memory is a pure function of the
// address. The expected program stream is a queue of PCs: straight-line
// order from RESET_PC, restarted at the target on every redirect/reset.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redir;
  logic [31:0] rpc;
  logic        req, ack;
  logic [31:0] addr, data;
  logic [31:0] instr, opc;
  logic        valid;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  logic [31:0] exp_q[$];
  int          busy, wait_left;

  // Monitor history and protocol-level reference state
  logic        primed, stale, live;
  logic [31:0] exp_fetch;
  logic        p_rst, p_redir, p_stall, p_valid, p_req, p_ack, p_live;
  logic [31:0] p_addr, p_pc, p_instr;

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_stall      (stall),
    .I_redirect   (redir),
    .I_redirect_pc(rpc),
    .O_imem_req   (req),
    .O_imem_addr  (addr),
    .I_imem_ack   (ack),
    .I_imem_data  (data),
    .O_instr      (instr),
    .O_pc         (opc),
    .O_valid      (valid)
  );

  always #5 clk = ~clk;

  // Memory contents: two fixed words at the start, a bijective hash elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_8463;
    if (a == 32'h4) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus: drive control inputs at the falling edge,
  // update the expected stream, then let the memory model answer the request.
  task automatic applyStimulus(input logic rst_i, input logic stall_i, input logic redir_i,
                               input logic [31:0] rpc_i, input int wmin, input int wmax);
    @(negedge clk);
    if (rst || ack) busy = 0;
    else if (busy != 0) wait_left--;
    rst   = rst_i;
    stall = stall_i;
    redir = redir_i;
    rpc   = rpc_i;
    if (rst_i) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
    end else if (redir_i) begin
      exp_q.delete();
      exp_q.push_back(rpc_i & 32'hFFFF_FFFC);
    end
    while (exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
    #1;
    if (rst_i) begin
      // a late ack from the aborted read lands in the reset cycle
      ack  = (busy != 0);
      data = 32'hBAD0_BAD0;
    end else if (req) begin
      if (busy == 0) begin
        busy      = 1;
        wait_left = $urandom_range(wmax, wmin);
      end
      ack  = (wait_left == 0);
      data = ack ? mem_word(addr) : $urandom;
    end else begin
      ack  = 1'b0;
      data = $urandom;
    end
  endtask

  // Monitor: samples between edges and checks handshake rules, register
  // behaviour relative to the previous cycle, and pops the scoreboard on
  // every consumed instruction.
  initial begin
    primed    = 1'b0;
    stale     = 1'b0;
    exp_fetch = RESET_PC;
    forever begin
      @(negedge clk);
      #2;
      live = req && ack && !stale && !redir && !rst;
      if (primed) begin
        if (rst) checkOutput("req_in_reset", 32'(req), 32'd0);
        if (p_rst) begin
          checkOutput("reset_valid", 32'(valid), 32'd0);
          checkOutput("reset_instr", instr, NOP_INSTR);
          checkOutput("reset_pc", opc, RESET_PC);
        end else if (p_redir) begin
          checkOutput("flush_valid", 32'(valid), 32'd0);
          checkOutput("flush_instr", instr, NOP_INSTR);
        end else if (p_valid && p_stall) begin
          checkOutput("stall_valid", 32'(valid), 32'd1);
          checkOutput("stall_pc", opc, p_pc);
          checkOutput("stall_instr", instr, p_instr);
        end else if (p_live) begin
          checkOutput("ack_valid", 32'(valid), 32'd1);
          checkOutput("ack_pc", opc, p_addr);
          checkOutput("ack_instr", instr, mem_word(p_addr));
        end
        if (p_req && p_ack && !rst)
          checkOutput("req_after_ack", 32'(req), 32'(!(p_live && p_valid && p_stall)));
        if (p_req && !p_ack && !rst) begin
          checkOutput("req_hold", 32'(req), 32'd1);
          checkOutput("addr_hold", addr, p_addr);
        end
      end
      if (req && !(primed && p_req && !p_ack))
        checkOutput("fetch_addr", addr, exp_fetch);
      if (valid && !stall && !redir && !rst) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checkOutput("stream_empty", opc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checkOutput("stream_pc", opc, e);
          checkOutput("stream_instr", instr, mem_word(e));
        end
      end
      if (rst) begin
        stale     = 1'b0;
        exp_fetch = RESET_PC;
      end else begin
        if (req && ack) stale = 1'b0;
        else if (req && redir) stale = 1'b1;
        if (redir) exp_fetch = rpc & 32'hFFFF_FFFC;
        else if (live) exp_fetch = exp_fetch + 32'd4;
      end
      p_rst   = rst;
      p_redir = redir;
      p_stall = stall;
      p_valid = valid;
      p_req   = req;
      p_ack   = ack;
      p_live  = live;
      p_addr  = addr;
      p_pc    = opc;
      p_instr = instr;
      primed  = 1'b1;
    end
  end

  // Directed scenarios followed by a long randomized run
  initial begin
    logic [31:0] saved;
    logic        found;
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    ack = 1'b0; data = '0; busy = 0; wait_left = 0;
    exp_q.push_back(RESET_PC);

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #2 checkOutput("rst_req_low", 32'(req), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("first_valid", 32'(valid), 32'd0);
    checkOutput("first_instr", instr, NOP_INSTR);
    checkOutput("first_req", 32'(req), 32'd1);
    checkOutput("first_addr", addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("w0_instr", instr, 32'h0020_8463);
    checkOutput("w0_pc", opc, 32'h0);
    checkOutput("w0_valid", 32'(valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("w1_instr", instr, 32'h0000_0013);
    checkOutput("w1_pc", opc, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2 checkOutput("step_addr", addr, 32'hC);

    // hold the stall long enough for the skid to fill and block requests
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      #2;
      if (i > 0) checkOutput("skid_blocks_req", 32'(req), 32'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // redirect while a slow read is outstanding
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(0, 0, 0, 0, 2, 2);
      if (req && !ack && wait_left == 2) found = 1'b1;
    end
    checkOutput("drop_setup", 32'(found), 32'd1);
    saved = addr;
    applyStimulus(0, 0, 1, 32'h100, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("drop_valid", 32'(valid), 32'd0);
    checkOutput("drop_req", 32'(req), 32'd1);
    checkOutput("drop_addr", addr, saved);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      #2 if (valid) found = 1'b1;
    end
    checkOutput("target_seen", 32'(found), 32'd1);
    checkOutput("target_pc", opc, 32'h100);

    // redirect coinciding with an ack: no drain cycle
    applyStimulus(0, 0, 1, 32'h200, 0, 0);
    #2 checkOutput("req_at_redirect", 32'(req), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("nodrop_req", 32'(req), 32'd1);
    checkOutput("nodrop_addr", addr, 32'h200);
    checkOutput("nodrop_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // reset while a read is outstanding, with the late ack during reset
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(0, 0, 0, 0, 3, 3);
      if (req && !ack && wait_left == 3) found = 1'b1;
    end
    checkOutput("rst_setup", 32'(found), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #2 checkOutput("midrst_req", 32'(req), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    #2;
    checkOutput("midrst_valid", 32'(valid), 32'd0);
    checkOutput("midrst_instr", instr, NOP_INSTR);
    checkOutput("midrst_pc", opc, RESET_PC);
    checkOutput("midrst_addr", addr, RESET_PC);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1);

    // wrap past the top of the address space, unaligned target
    applyStimulus(0, 0, 1, 32'hFFFF_FFF9, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [31:0] t;
      r = $urandom_range(999, 0);
      t = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
      applyStimulus(r < 4, $urandom_range(99, 0) < 30, (r >= 4) && (r < 40), t,
                    0, ($urandom_range(3, 0) == 0) ? 0 : 3);
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("progress", 32'(consumed >= 500), 32'd1);

    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
